fb_mem_arbiter: RTL and testbench

FB_MEM_ARBITER -- requirements
Module: fb_mem_arbiter

---
 rtl/fb_mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fb_mem_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_mem_arbiter.sv
// Frame-buffer memory arbiter: shares one single-port synchronous RAM
// between a VGA pixel fetcher, a CPU port and a 32-bit word loader that
// writes its word as four byte beats. VGA always wins; the CPU can
// overtake the loader once it has been starved for eight cycles.
module fb_mem_arbiter #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // VGA pixel-fetch read port
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  // CPU read/write port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  // Loader word-write port
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  // RAM side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {LD_IDLE, LD_BURST} ld_state_e;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;

  ld_state_e         ld_state_q, ld_state_d;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ld_data_q;
  logic [1:0]        beat_q;
  logic [3:0]        starve_q, starve_d;
  logic              ld_gnt;
  logic              ld_active;
  logic              cpu_boost;
  logic [7:0]        beat_byte;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        tag1_q, tag2_q, tag_d;
  logic [DATA_W-1:0] vga_hold_q, cpu_hold_q;

  // Loader FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ld_state_q <= LD_IDLE;
    else        ld_state_q <= ld_state_d;
  end

  // Loader FSM next state: accept a word in IDLE, leave BURST after beat 3 is granted
  always_comb begin
    ld_state_d = ld_state_q;
    case (ld_state_q)
      LD_IDLE:  if (ld_valid && ld_ready) ld_state_d = LD_BURST;
      LD_BURST: if (ld_gnt && (beat_q == 2'd3)) ld_state_d = LD_IDLE;
      default:  ld_state_d = LD_IDLE;
    endcase
  end

  // Grants and loader handshake; everything is held off while reset is low
  always_comb begin
    ld_active = (ld_state_q == LD_BURST);
    cpu_boost = starve_q[3];
    vga_gnt   = reset & vga_req;
    cpu_gnt   = reset & cpu_req & ~vga_req & (~ld_active | cpu_boost);
    ld_gnt    = reset & ld_active & ~vga_req & ~(cpu_req & cpu_boost);
    ld_ready  = reset & ~ld_active;
  end

  // Loader word capture and beat counter; denied beats keep their index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_addr_q <= '0;
      ld_data_q <= '0;
      beat_q    <= '0;
    end else if (ld_valid && ld_ready) begin
      ld_addr_q <= ld_addr;
      ld_data_q <= ld_data;
      beat_q    <= 2'd0;
    end else if (ld_gnt) begin
      beat_q    <= beat_q + 2'd1;
    end
  end

  // Starvation count: cleared by a CPU grant, saturates so it never wraps below 8
  always_comb begin
    starve_d = starve_q;
    if (cpu_gnt)                           starve_d = 4'd0;
    else if (cpu_req && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= 4'd0;
    else        starve_q <= starve_d;
  end

  // Memory command for the winner; address wraps naturally at 2^ADDR_W
  always_comb begin
    beat_byte   = ld_data_q[8*beat_q +: 8];
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    tag_d       = TAG_NONE;
    if (vga_gnt) begin
      mem_addr_d = vga_addr;
      tag_d      = TAG_VGA;
    end else if (cpu_gnt) begin
      mem_addr_d = cpu_addr;
      if (cpu_we) begin
        mem_we_d    = 1'b1;
        mem_wdata_d = cpu_wdata;
      end else begin
        tag_d = TAG_CPU;
      end
    end else if (ld_gnt) begin
      mem_addr_d  = ld_addr_q + ADDR_W'(beat_q);
      mem_we_d    = 1'b1;
      mem_wdata_d = DATA_W'(beat_byte);
    end
  end

  // Registered RAM command and two-stage read-owner tag pipeline
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      tag1_q      <= tag_d;
      tag2_q      <= tag1_q;
    end
  end

  // Keep the last returned byte for each reader so rdata is stable between pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_hold_q <= '0;
      cpu_hold_q <= '0;
    end else begin
      if (vga_rvalid) vga_hold_q <= mem_rdata;
      if (cpu_rvalid) cpu_hold_q <= mem_rdata;
    end
  end

  // Route RAM read data to its owner in the cycle it arrives
  always_comb begin
    vga_rvalid = (tag2_q == TAG_VGA);
    cpu_rvalid = (tag2_q == TAG_CPU);
    vga_rdata  = vga_rvalid ? mem_rdata : vga_hold_q;
    cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_hold_q;
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Self-checking bench for fb_mem_arbiter: a behavioural RAM, a scoreboard
// of expected writes/read returns, a grant table and corner-case sequences.
module tb_fb_mem_arbiter;

  localparam int AW = 18;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          vga_req, vga_gnt, vga_rvalid;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_rdata;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ld_valid, ld_ready;
  logic [AW-1:0] ld_addr;
  logic [31:0]   ld_data;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  fb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Power-up RAM contents; 0x00010 holds 0x5A
  function automatic logic [7:0] pattern(input logic [AW-1:0] a);
    if (a == 18'h00010) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Behavioural single-port RAM, one-cycle read latency, read-before-write
  logic [7:0] ram [int];
  always @(posedge clk) begin
    mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pattern(mem_addr);
    if (mem_we) ram[int'(mem_addr)] = mem_wdata;
  end

  // Scoreboard
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;
  wr_t        wr_q[$];
  logic [7:0] vga_q[$];
  logic [7:0] cpu_q[$];
  logic [7:0] exp_mem [int];

  function automatic logic [7:0] exp_rd(input logic [AW-1:0] a);
    return exp_mem.exists(int'(a)) ? exp_mem[int'(a)] : pattern(a);
  endfunction

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    wr_q.push_back(e);
    exp_mem[int'(a)] = d;
  endtask

  task automatic push_vga(input logic [AW-1:0] a);
    vga_q.push_back(exp_rd(a));
  endtask

  task automatic push_cpu(input logic [AW-1:0] a);
    cpu_q.push_back(exp_rd(a));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [AW-1:0] a, input logic [31:0] d);
    for (int k = 0; k < 4; k++) push_wr(a + AW'(k), d[8*k +: 8]);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every RAM write and every read return must match the scoreboard
  always @(negedge clk) begin : mon
    wr_t        e;
    logic [7:0] d;
    if (mem_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, required none", mem_addr, mem_wdata);
      end else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
        $display("write  0x%05h <= 0x%02h", mem_addr, mem_wdata);
      end
    end
    if (vga_rvalid === 1'b1) begin
      if (vga_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_vga_rvalid: got data 0x%0h, required none", vga_rdata);
      end else begin
        d = vga_q.pop_front();
        chk("vga_rdata", 32'(vga_rdata), 32'(d));
        $display("vga rd -> 0x%02h", vga_rdata);
      end
    end
    if (cpu_rvalid === 1'b1) begin
      if (cpu_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_cpu_rvalid: got data 0x%0h, required none", cpu_rdata);
      end else begin
        d = cpu_q.pop_front();
        chk("cpu_rdata", 32'(cpu_rdata), 32'(d));
        $display("cpu rd -> 0x%02h", cpu_rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100us");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          creq;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [7:0]    cwdata;
    logic          exp_vg;
    logic          exp_cg;
  } vec_t;

  vec_t          vecs[9];
  logic [AW-1:0] w_addr[4];
  logic [7:0]    w_byte[4];
  logic [AW-1:0] rb_addr[3];

  initial begin
    vecs[0] = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h00020, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 18'h00100, 1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 18'h00101, 1'b1, 1'b0, 18'h00200, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 18'h00000, 1'b1, 1'b1, 18'h00300, 8'h77, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h00300, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 18'h00000, 1'b0, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 18'h00102, 1'b1, 1'b1, 18'h00301, 8'h66, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 18'h3FFFF, 1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 18'h00000, 1'b1, 1'b0, 18'h00040, 8'h00, 1'b0, 1'b1};
    w_addr = '{18'h3FFFE, 18'h3FFFF, 18'h00000, 18'h00001};
    w_byte = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    rb_addr = '{18'h08002, 18'h3FFFF, 18'h00000};

    vga_req = 0; vga_addr = '0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_valid = 0; ld_addr = '0; ld_data = '0;

    // ---- reset state, with requests present ----
    #1 reset = 1'b0;
    vga_req = 1; cpu_req = 1; cpu_we = 1; ld_valid = 1;
    #3;
    chk("rst_vga_gnt", 32'(vga_gnt), 0);
    chk("rst_cpu_gnt", 32'(cpu_gnt), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_vga_rvalid", 32'(vga_rvalid), 0);
    chk("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    chk("rst_vga_rdata", 32'(vga_rdata), 0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
    @(posedge clk); @(posedge clk); #1;
    chk("rst_hold_mem_we", 32'(mem_we), 0);
    chk("rst_hold_vga_gnt", 32'(vga_gnt), 0);
    vga_req = 0; cpu_req = 0; cpu_we = 0; ld_valid = 0;
    next_cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_ld_ready", 32'(ld_ready), 1);
    next_cyc();

    // ---- lone CPU read of 0x00010: gnt N, addr N+1, rvalid N+2 ----
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00010;
    @(negedge clk);
    chk("cpu_rd_gnt", 32'(cpu_gnt), 1);
    push_cpu(18'h00010);
    $display("cpu read 0x00010 issued");
    next_cyc();
    cpu_req = 0;
    @(negedge clk);
    chk("cpu_rd_mem_addr", 32'(mem_addr), 32'h10);
    chk("cpu_rd_mem_we", 32'(mem_we), 0);
    chk("cpu_rd_early_rvalid", 32'(cpu_rvalid), 0);
    next_cyc();
    @(negedge clk);
    chk("cpu_rd_rvalid", 32'(cpu_rvalid), 1);
    chk("cpu_rd_data", 32'(cpu_rdata), 32'h5A);
    next_cyc();
    @(negedge clk);
    chk("cpu_rd_pulse_end", 32'(cpu_rvalid), 0);
    chk("cpu_rd_data_hold", 32'(cpu_rdata), 32'h5A);
    next_cyc();

    // ---- grant priority table (loader idle) ----
    for (int i = 0; i < 9; i++) begin
      vga_req = vecs[i].vreq; vga_addr = vecs[i].vaddr;
      cpu_req = vecs[i].creq; cpu_we = vecs[i].cwe;
      cpu_addr = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      @(negedge clk);
      chk($sformatf("vec%0d_vga_gnt", i), 32'(vga_gnt), 32'(vecs[i].exp_vg));
      chk($sformatf("vec%0d_cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].exp_cg));
      chk($sformatf("vec%0d_ld_ready", i), 32'(ld_ready), 1);
      if (vecs[i].exp_vg) push_vga(vecs[i].vaddr);
      if (vecs[i].exp_cg) begin
        if (vecs[i].cwe) push_wr(vecs[i].caddr, vecs[i].cwdata);
        else             push_cpu(vecs[i].caddr);
      end
      $display("vec %0d: vga_req=%0b cpu_req=%0b we=%0b", i, vecs[i].vreq, vecs[i].creq, vecs[i].cwe);
      next_cyc();
    end
    vga_req = 0; cpu_req = 0; cpu_we = 0;
    for (int i = 0; i < 3; i++) next_cyc();

    // ---- loader word wrapping past the top of memory ----
    ld_valid = 1; ld_addr = 18'h3FFFE; ld_data = 32'hDDCCBBAA;
    @(negedge clk);
    chk("wrap_accept_ready", 32'(ld_ready), 1);
    push_word(18'h3FFFE, 32'hDDCCBBAA);
    $display("loader word 0xDDCCBBAA @ 0x3FFFE");
    next_cyc();
    ld_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_ready_low%0d", k), 32'(ld_ready), 0);
      if (k >= 1) begin
        chk($sformatf("wrap_we%0d", k - 1), 32'(mem_we), 1);
        chk($sformatf("wrap_addr%0d", k - 1), 32'(mem_addr), 32'(w_addr[k-1]));
        chk($sformatf("wrap_data%0d", k - 1), 32'(mem_wdata), 32'(w_byte[k-1]));
      end
      next_cyc();
    end
    @(negedge clk);
    chk("wrap_ready_back", 32'(ld_ready), 1);
    chk("wrap_we3", 32'(mem_we), 1);
    chk("wrap_addr3", 32'(mem_addr), 32'(w_addr[3]));
    chk("wrap_data3", 32'(mem_wdata), 32'(w_byte[3]));
    next_cyc();
    @(negedge clk);
    chk("wrap_we_done", 32'(mem_we), 0);
    next_cyc();

    // ---- VGA holds off loader beat 1 for three cycles ----
    ld_valid = 1; ld_addr = 18'h01000; ld_data = 32'h44332211;
    @(negedge clk);
    push_word(18'h01000, 32'h44332211);
    $display("loader word 0x44332211 @ 0x01000");
    next_cyc();
    ld_valid = 0;
    @(negedge clk);
    chk("stall_beat0_vga_gnt", 32'(vga_gnt), 0);
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      vga_req = 1; vga_addr = 18'h02000 + AW'(i);
      @(negedge clk);
      chk($sformatf("stall_vga_gnt%0d", i), 32'(vga_gnt), 1);
      chk($sformatf("stall_ready%0d", i), 32'(ld_ready), 0);
      chk($sformatf("stall_we%0d", i), 32'(mem_we), (i == 0) ? 1 : 0);
      push_vga(18'h02000 + AW'(i));
      next_cyc();
    end
    vga_req = 0;
    @(negedge clk);
    chk("stall_we_after_vga", 32'(mem_we), 0);
    chk("stall_ready_b1", 32'(ld_ready), 0);
    next_cyc();
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("resume_addr%0d", k), 32'(mem_addr), 32'h1000 + k);
      chk($sformatf("resume_ready%0d", k), 32'(ld_ready), (k == 3) ? 1 : 0);
      next_cyc();
    end

    // ---- CPU starvation: boost after 8 denials, counter then cleared ----
    ld_valid = 1; ld_addr = 18'h04000; ld_data = 32'h88776655;
    @(negedge clk);
    chk("starve_accept_ready", 32'(ld_ready), 1);
    push_word(18'h04000, 32'h88776655);
    next_cyc();
    ld_valid = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 18'h00500;
    for (int t = 0; t < 9; t++) begin
      vga_req = (t >= 1 && t <= 5); vga_addr = 18'h00600 + AW'(t);
      @(negedge clk);
      chk($sformatf("starve_cpu_gnt_t%0d", t), 32'(cpu_gnt), (t == 8) ? 1 : 0);
      chk($sformatf("starve_vga_gnt_t%0d", t), 32'(vga_gnt), (t >= 1 && t <= 5) ? 1 : 0);
      if (t >= 1 && t <= 5) push_vga(18'h00600 + AW'(t));
      if (t == 8) push_cpu(18'h00500);
      $display("starve cycle %0d: cpu_gnt=%0b", t, cpu_gnt);
      next_cyc();
    end
    vga_req = 0; cpu_addr = 18'h00501;
    @(negedge clk);
    chk("starve_cleared_loader_wins", 32'(cpu_gnt), 0);
    next_cyc();
    @(negedge clk);
    chk("starve_idle_cpu_gnt", 32'(cpu_gnt), 1);
    chk("starve_idle_ready", 32'(ld_ready), 1);
    push_cpu(18'h00501);
    next_cyc();
    cpu_req = 0;
    for (int i = 0; i < 3; i++) next_cyc();

    // ---- reset during beat 2 with a VGA read in flight ----
    ld_valid = 1; ld_addr = 18'h08000; ld_data = 32'hCCBBAA99;
    @(negedge clk);
    push_wr(18'h08000, 8'h99);
    push_wr(18'h08001, 8'hAA);
    $display("loader word 0xCCBBAA99 @ 0x08000 (to be aborted)");
    next_cyc();
    ld_valid = 0;
    next_cyc();
    next_cyc();
    vga_req = 1; vga_addr = 18'h00700;
    @(negedge clk);
    chk("abort_vga_gnt", 32'(vga_gnt), 1);
    next_cyc();
    vga_req = 0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("abort_mem_we_now", 32'(mem_we), 0);
    chk("abort_ready_in_rst", 32'(ld_ready), 0);
    chk("abort_rvalid_now", 32'(vga_rvalid), 0);
    next_cyc();
    @(negedge clk);
    chk("abort_no_vga_rvalid", 32'(vga_rvalid), 0);
    chk("abort_mem_we_edge", 32'(mem_we), 0);
    next_cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_after_rel", 32'(ld_ready), 1);
    next_cyc();
    @(negedge clk);
    chk("abort_still_idle", 32'(ld_ready), 1);
    chk("abort_no_late_we", 32'(mem_we), 0);
    next_cyc();

    // ---- read back: aborted byte untouched, wrapped bytes present ----
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1; cpu_we = 0; cpu_addr = rb_addr[i];
      @(negedge clk);
      chk($sformatf("rb_gnt%0d", i), 32'(cpu_gnt), 1);
      push_cpu(rb_addr[i]);
      $display("readback 0x%05h", rb_addr[i]);
      next_cyc();
    end
    cpu_req = 0;
    for (int i = 0; i < 4; i++) next_cyc();

    chk("sb_writes_left", 32'(wr_q.size()), 0);
    chk("sb_vga_left", 32'(vga_q.size()), 0);
    chk("sb_cpu_left", 32'(cpu_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
